// File: rtl/psr_exception_unit_pkg.sv
// Shared types and tables for the LEG CPSR/SPSR exception unit: processor modes,
// sequencer states, per-channel exception tables and the mode-to-bank lookup.
package leg_psr_pkg;

    typedef enum logic [4:0] {
        MODE_USR = 5'b10000,
        MODE_FIQ = 5'b10001,
        MODE_IRQ = 5'b10010,
        MODE_SVC = 5'b10011,
        MODE_ABT = 5'b10111,
        MODE_UND = 5'b11011,
        MODE_SYS = 5'b11111
    } mode_e;

    // Bit m set when mode value m is architecturally legal.
    localparam logic [31:0] MODE_LEGAL = 32'h888F_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTER  = 2'd1,
        VECTOR = 2'd2
    } state_e;

    localparam logic [31:0] CPSR_RESET = 32'h0000_00D3;

    localparam logic [2:0] BANK_SVC  = 3'd0;
    localparam logic [2:0] BANK_ABT  = 3'd1;
    localparam logic [2:0] BANK_UND  = 3'd2;
    localparam logic [2:0] BANK_IRQ  = 3'd3;
    localparam logic [2:0] BANK_FIQ  = 3'd4;
    localparam logic [2:0] BANK_NONE = 3'd7;

    localparam logic [1:0] MASK_NONE = 2'd0;
    localparam logic [1:0] MASK_I    = 2'd1;
    localparam logic [1:0] MASK_F    = 2'd2;

    // Channel map: [0]dabt [1]fiq [2]irq [3]pabt [4]und [5]swi, [6..7] spare (swi-like).
    localparam logic [7:0][4:0] EXC_MODE = {
        MODE_SVC, MODE_SVC, MODE_SVC, MODE_UND,
        MODE_ABT, MODE_IRQ, MODE_FIQ, MODE_ABT
    };
    localparam logic [7:0][2:0] EXC_BANK = {
        BANK_SVC, BANK_SVC, BANK_SVC, BANK_UND,
        BANK_ABT, BANK_IRQ, BANK_FIQ, BANK_ABT
    };
    localparam logic [7:0][7:0] EXC_VEC = {
        8'h04, 8'h04, 8'h04, 8'h02,
        8'h08, 8'h20, 8'h40, 8'h10
    };
    localparam logic [7:0] EXC_LEVEL = 8'b0000_0110;
    localparam logic [7:0] EXC_SET_F = 8'b0000_0010;
    localparam logic [7:0][1:0] EXC_MASKBIT = {
        MASK_NONE, MASK_NONE, MASK_NONE, MASK_NONE,
        MASK_NONE, MASK_I, MASK_F, MASK_NONE
    };

    function automatic logic [2:0] mode_to_bank(input logic [4:0] mode);
        case (mode)
            MODE_SVC: return BANK_SVC;
            MODE_ABT: return BANK_ABT;
            MODE_UND: return BANK_UND;
            MODE_IRQ: return BANK_IRQ;
            MODE_FIQ: return BANK_FIQ;
            default:  return BANK_NONE;
        endcase
    endfunction

endpackage

// File: rtl/psr_exception_unit_if.sv
// Vector hand-off from the exception unit (master) to fetch (slave).
interface psr_exception_unit_if #(
    parameter int VEC_W = 7
);
    logic             vec_valid;
    logic             vec_ready;
    logic [VEC_W-1:0] vec_addr;
    logic [2:0]       exc_cause;

    modport master (output vec_valid, output vec_addr, output exc_cause, input vec_ready);
    modport slave  (input vec_valid, input vec_addr, input exc_cause, output vec_ready);
endinterface

// File: rtl/psr_exception_unit_prio_arbiter.sv
// Fixed-priority encoder: lowest set index wins.
module psr_prio_arbiter #(
    parameter int N = 6
) (
    input  logic [N-1:0] i_req,
    output logic         o_valid,
    output logic [2:0]   o_idx
);
    always_comb begin
        o_valid = 1'b0;
        o_idx   = 3'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_valid = 1'b1;
                o_idx   = 3'(i);
            end
        end
    end
endmodule

// File: rtl/psr_exception_unit.sv
// CPSR / banked SPSR unit with registered exception-entry sequencer for the LEG execute stage.
// Optional LEG_PSR_EXC_COUNT_EN adds per-channel saturating entry counters on exc_count.
module psr_exception_unit
    import leg_psr_pkg::*;
#(
    parameter int NUM_EXC  = 6,
    parameter int NUM_BANK = 5,
    parameter int VEC_W    = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_EXC-1:0]   exc_req,
    input  logic                 flags_we,
    input  logic [3:0]           flags_next,
    input  logic                 msr_we,
    input  logic                 msr_spsr,
    input  logic [3:0]           msr_mask,
    input  logic [31:0]          msr_data,
    input  logic                 restore_cpsr,
    output logic [31:0]          cpsr_o,
    output logic [31:0]          spsr_o,
    output logic                 busy,
`ifdef LEG_PSR_EXC_COUNT_EN
    output logic [NUM_EXC*16-1:0] exc_count,
`endif
    psr_exception_unit_if.master vec_if
);

    state_e             r_state;
    logic [31:0]        r_cpsr;
    logic [31:0]        r_spsr [NUM_BANK];
    logic [NUM_EXC-1:0] r_pending;
    logic [2:0]         r_cause;
    logic [VEC_W-1:0]   r_vec_addr;

    logic [NUM_EXC-1:0] w_active;
    logic [NUM_EXC-1:0] w_masked;
    logic [NUM_EXC-1:0] w_eligible;
    logic [NUM_EXC-1:0] w_take;
    logic [NUM_EXC-1:0] w_pending_next;
    logic               w_arb_valid;
    logic [2:0]         w_arb_idx;
    logic [2:0]         w_cur_bank;
    logic               w_bank_ok;
    logic               w_priv;
    logic [31:0]        w_cur_spsr;
    logic [31:0]        w_msr_cpsr;
    logic [31:0]        w_msr_spsr;
    logic [31:0]        w_enter_cpsr;
    logic [2:0]         w_enter_bank;

    // Byte-lane MSR merge; unprivileged writers only reach the flag byte and
    // an illegal mode value leaves the mode field as it was.
    function automatic logic [31:0] msr_merge(input logic [31:0] old_val, input logic [31:0] data,
                                              input logic [3:0] mask, input logic priv);
        logic [31:0] res;
        res = old_val;
        if (mask[3]) res[31:24] = data[31:24];
        if (priv) begin
            if (mask[2]) res[23:16] = data[23:16];
            if (mask[1]) res[15:8]  = data[15:8];
            if (mask[0]) begin
                res[7:5] = data[7:5];
                if (MODE_LEGAL[data[4:0]]) res[4:0] = data[4:0];
            end
        end
        return res;
    endfunction

    // Level channels (irq/fiq) bypass the sticky latch and follow the live input.
    generate
        for (genvar gi = 0; gi < NUM_EXC; gi++) begin : g_chan
            assign w_active[gi] = EXC_LEVEL[gi] ? exc_req[gi] : (r_pending[gi] | exc_req[gi]);
            assign w_masked[gi] = ((EXC_MASKBIT[gi] == MASK_I) & r_cpsr[7]) |
                                  ((EXC_MASKBIT[gi] == MASK_F) & r_cpsr[6]);
            assign w_eligible[gi] = w_active[gi] & ~w_masked[gi];
            assign w_take[gi] = (r_state == ENTER) && (r_cause == 3'(gi));
            assign w_pending_next[gi] = EXC_LEVEL[gi] ? 1'b0
                                      : (exc_req[gi] | (r_pending[gi] & ~w_take[gi]));
        end
    endgenerate

    psr_prio_arbiter #(.N(NUM_EXC)) u_arb (
        .i_req   (w_eligible),
        .o_valid (w_arb_valid),
        .o_idx   (w_arb_idx)
    );

    assign w_cur_bank   = mode_to_bank(r_cpsr[4:0]);
    assign w_bank_ok    = int'(w_cur_bank) < NUM_BANK;
    assign w_priv       = (r_cpsr[4:0] != MODE_USR);
    assign w_cur_spsr   = w_bank_ok ? r_spsr[w_cur_bank] : r_cpsr;
    assign w_msr_cpsr   = msr_merge(r_cpsr, msr_data, msr_mask, w_priv);
    assign w_msr_spsr   = msr_merge(w_cur_spsr, msr_data, msr_mask, 1'b1);
    assign w_enter_bank = EXC_BANK[r_cause];
    assign w_enter_cpsr = {r_cpsr[31:8], 1'b1, (EXC_SET_F[r_cause] | r_cpsr[6]), 1'b0,
                           EXC_MODE[r_cause]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cpsr     <= CPSR_RESET;
            r_pending  <= '0;
            r_cause    <= '0;
            r_vec_addr <= '0;
            for (int b = 0; b < NUM_BANK; b++) r_spsr[b] <= '0;
        end else begin
            r_pending <= w_pending_next;
            case (r_state)
                IDLE: begin
                    // One architectural write per cycle; exception detect wins.
                    if (w_arb_valid) begin
                        r_state <= ENTER;
                        r_cause <= w_arb_idx;
                    end else if (msr_we) begin
                        if (msr_spsr) begin
                            if (w_bank_ok) r_spsr[w_cur_bank] <= w_msr_spsr;
                        end else begin
                            r_cpsr <= w_msr_cpsr;
                        end
                    end else if (restore_cpsr) begin
                        if (w_bank_ok) r_cpsr <= w_cur_spsr;
                    end else if (flags_we) begin
                        r_cpsr[31:28] <= flags_next;
                    end
                end
                ENTER: begin
                    if (int'(w_enter_bank) < NUM_BANK) r_spsr[w_enter_bank] <= r_cpsr;
                    r_cpsr     <= w_enter_cpsr;
                    r_vec_addr <= EXC_VEC[r_cause][VEC_W-1:0];
                    r_state    <= VECTOR;
                end
                VECTOR: begin
                    if (vec_if.vec_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef LEG_PSR_EXC_COUNT_EN
    logic [15:0] r_exc_cnt [NUM_EXC];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_EXC; i++) r_exc_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_EXC; i++) begin
                if (w_take[i] && (r_exc_cnt[i] != 16'hFFFF)) r_exc_cnt[i] <= r_exc_cnt[i] + 16'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_EXC; gi++) begin : g_cnt
            assign exc_count[gi*16 +: 16] = r_exc_cnt[gi];
        end
    endgenerate
`endif

    assign cpsr_o           = r_cpsr;
    assign spsr_o           = w_cur_spsr;
    assign busy             = (r_state != IDLE);
    assign vec_if.vec_valid = (r_state == VECTOR);
    assign vec_if.vec_addr  = r_vec_addr;
    assign vec_if.exc_cause = r_cause;

endmodule

// File: tb/tb_psr_exception_unit.sv
// Self-checking bench for psr_exception_unit: directed scenarios then random traffic against
// a behavioural model. Define LEG_PSR_EXC_COUNT_EN to also check the entry counters.
module tb_psr_exception_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  exc_req;
    logic        flags_we;
    logic [3:0]  flags_next;
    logic        msr_we;
    logic        msr_spsr;
    logic [3:0]  msr_mask;
    logic [31:0] msr_data;
    logic        restore_cpsr;
    logic [31:0] cpsr_o;
    logic [31:0] spsr_o;
    logic        busy;
`ifdef LEG_PSR_EXC_COUNT_EN
    logic [95:0] exc_count;
`endif

    psr_exception_unit_if #(.VEC_W(7)) vif ();

    always #5 clk = ~clk;

    psr_exception_unit #(.NUM_EXC(6), .NUM_BANK(5), .VEC_W(7)) dut (
        .clk          (clk),
        .reset        (reset),
        .exc_req      (exc_req),
        .flags_we     (flags_we),
        .flags_next   (flags_next),
        .msr_we       (msr_we),
        .msr_spsr     (msr_spsr),
        .msr_mask     (msr_mask),
        .msr_data     (msr_data),
        .restore_cpsr (restore_cpsr),
        .cpsr_o       (cpsr_o),
        .spsr_o       (spsr_o),
        .busy         (busy),
`ifdef LEG_PSR_EXC_COUNT_EN
        .exc_count    (exc_count),
`endif
        .vec_if       (vif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = no exception in flight, 1 = entry cycle, 2 = vector offered to fetch
    bit [31:0] m_cpsr;
    bit [31:0] m_spsr [5];
    bit [5:0]  m_pend;
    int        m_phase;
    int        m_cause;
    bit [6:0]  m_vec;
    int        m_cnt [6];

    function automatic int bank_of(input bit [4:0] m);
        case (m)
            5'b10011: return 0;
            5'b10111: return 1;
            5'b11011: return 2;
            5'b10010: return 3;
            5'b10001: return 4;
            default:  return -1;
        endcase
    endfunction

    function automatic bit [4:0] mode_of_exc(input int c);
        case (c)
            0, 3:    return 5'b10111;
            1:       return 5'b10001;
            2:       return 5'b10010;
            4:       return 5'b11011;
            default: return 5'b10011;
        endcase
    endfunction

    function automatic bit [6:0] vec_of(input int c);
        case (c)
            0:       return 7'b0010000;
            1:       return 7'b1000000;
            2:       return 7'b0100000;
            3:       return 7'b0001000;
            4:       return 7'b0000010;
            default: return 7'b0000100;
        endcase
    endfunction

    function automatic bit legal_mode(input bit [4:0] m);
        return m inside {5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10111, 5'b11011, 5'b11111};
    endfunction

    function automatic bit [31:0] apply_msr(input bit [31:0] old_v, input bit [31:0] d,
                                            input bit [3:0] mask, input bit priv);
        bit [31:0] v;
        v = old_v;
        if (mask[3]) v[31:24] = d[31:24];
        if (priv && mask[2]) v[23:16] = d[23:16];
        if (priv && mask[1]) v[15:8] = d[15:8];
        if (priv && mask[0]) begin
            v[7:5] = d[7:5];
            if (legal_mode(d[4:0])) v[4:0] = d[4:0];
        end
        return v;
    endfunction

    task automatic model_reset();
        m_cpsr  = 32'h0000_00D3;
        m_pend  = '0;
        m_phase = 0;
        m_cause = 0;
        m_vec   = '0;
        for (int b = 0; b < 5; b++) m_spsr[b] = '0;
        for (int c = 0; c < 6; c++) m_cnt[c] = 0;
    endtask

    task automatic model_step();
        bit [5:0] pend_n;
        int win;
        int b;
        if (reset) begin
            model_reset();
            return;
        end
        pend_n = m_pend;
        b = bank_of(m_cpsr[4:0]);
        if (m_phase == 0) begin
            win = -1;
            for (int i = 0; i < 6; i++) begin
                bit req_on, msk;
                req_on = (i == 1 || i == 2) ? exc_req[i] : (m_pend[i] | exc_req[i]);
                msk    = (i == 2) ? m_cpsr[7] : ((i == 1) ? m_cpsr[6] : 1'b0);
                if (win < 0 && req_on && !msk) win = i;
            end
            if (win >= 0) begin
                m_phase = 1;
                m_cause = win;
            end else if (msr_we) begin
                if (msr_spsr) begin
                    if (b >= 0) m_spsr[b] = apply_msr(m_spsr[b], msr_data, msr_mask, 1'b1);
                end else begin
                    m_cpsr = apply_msr(m_cpsr, msr_data, msr_mask, m_cpsr[4:0] != 5'b10000);
                end
            end else if (restore_cpsr) begin
                if (b >= 0) m_cpsr = m_spsr[b];
            end else if (flags_we) begin
                m_cpsr[31:28] = flags_next;
            end
        end else if (m_phase == 1) begin
            int tb_bank;
            tb_bank = bank_of(mode_of_exc(m_cause));
            if (tb_bank >= 0) m_spsr[tb_bank] = m_cpsr;
            m_cpsr[4:0] = mode_of_exc(m_cause);
            m_cpsr[7]   = 1'b1;
            m_cpsr[5]   = 1'b0;
            if (m_cause == 1) m_cpsr[6] = 1'b1;
            pend_n[m_cause] = 1'b0;
            m_vec = vec_of(m_cause);
            if (m_cnt[m_cause] < 65535) m_cnt[m_cause]++;
            m_phase = 2;
        end else if (vif.vec_ready) begin
            $display("xfer cause=%0d vec=%b cpsr=%h", m_cause, m_vec, m_cpsr);
            m_phase = 0;
        end
        for (int i = 0; i < 6; i++)
            if (i != 1 && i != 2 && exc_req[i]) pend_n[i] = 1'b1;
        m_pend = pend_n;
    endtask

    task automatic compare_all();
        int b;
        b = bank_of(m_cpsr[4:0]);
        check("cpsr", cpsr_o, m_cpsr);
        check("spsr", spsr_o, (b >= 0) ? m_spsr[b] : m_cpsr);
        check("vec_valid", 32'(vif.vec_valid), 32'(m_phase == 2));
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("exc_cause", 32'(vif.exc_cause), 32'(m_cause));
        check("vec_addr", 32'(vif.vec_addr), 32'(m_vec));
`ifdef LEG_PSR_EXC_COUNT_EN
        for (int c = 0; c < 6; c++) check("exc_count", 32'(exc_count[c*16 +: 16]), 32'(m_cnt[c]));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        exc_req = '0; flags_we = 0; flags_next = '0; msr_we = 0; msr_spsr = 0;
        msr_mask = '0; msr_data = '0; restore_cpsr = 0;
    endtask

    task automatic do_msr(input bit spsr, input bit [3:0] mask, input bit [31:0] data);
        msr_we = 1; msr_spsr = spsr; msr_mask = mask; msr_data = data;
        tick();
        msr_we = 0; msr_spsr = 0; msr_mask = '0; msr_data = '0;
        $display("txn msr spsr=%0d mask=%b data=%h -> cpsr=%h spsr=%h", spsr, mask, data, cpsr_o, spsr_o);
    endtask

    // Pulse one latched request and complete the handshake immediately.
    task automatic take_exc(input int c);
        exc_req = '0;
        exc_req[c] = 1'b1;
        vif.vec_ready = 0;
        tick();
        exc_req = '0;
        tick();
        vif.vec_ready = 1;
        tick();
        vif.vec_ready = 0;
        $display("txn exception %0d -> cpsr=%h", c, cpsr_o);
    endtask

    logic [4:0] legal_tbl [7] = '{5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10111, 5'b11011, 5'b11111};

    initial begin
        idle_inputs();
        vif.vec_ready = 0;
        reset = 1;
        model_reset();
        tick();
        tick();
        reset = 0;
        tick();
        check("rst_cpsr", cpsr_o, 32'h0000_00D3);
        check("rst_vec_valid", 32'(vif.vec_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        $display("txn reset released cpsr=%h", cpsr_o);

        // Clear I/F, then swi with fetch stalled.
        do_msr(0, 4'b0001, 32'h0000_0013);
        check("msr_clear_if", cpsr_o, 32'h0000_0013);
        exc_req = 6'b100000;
        tick();
        exc_req = '0;
        check("swi_enter_busy", 32'(busy), 32'd1);
        check("swi_enter_novalid", 32'(vif.vec_valid), 32'd0);
        tick();
        check("swi_spsr", spsr_o, 32'h0000_0013);
        check("swi_mode", 32'(cpsr_o[4:0]), 32'h13);
        check("swi_I", 32'(cpsr_o[7]), 32'd1);
        check("swi_valid", 32'(vif.vec_valid), 32'd1);
        check("swi_vec", 32'(vif.vec_addr), 32'b0000100);
        tick();
        tick();
        check("swi_valid_held", 32'(vif.vec_valid), 32'd1);
        check("swi_vec_held", 32'(vif.vec_addr), 32'b0000100);
        vif.vec_ready = 1;
        tick();
        vif.vec_ready = 0;
        check("swi_valid_drop", 32'(vif.vec_valid), 32'd0);
        $display("txn swi vector accepted");

        // dabt/fiq/irq together; fiq and irq are levels held by the source.
        exc_req = 6'b000111;
        tick();
        exc_req = 6'b000110;
        check("multi_first_cause", 32'(vif.exc_cause), 32'd0);
        tick();
        check("dabt_mode", 32'(cpsr_o[4:0]), 32'b10111);
        check("dabt_vec", 32'(vif.vec_addr), 32'b0010000);
        vif.vec_ready = 1;
        tick();
        tick();
        check("fiq_cause", 32'(vif.exc_cause), 32'd1);
        tick();
        check("fiq_F", 32'(cpsr_o[6]), 32'd1);
        check("fiq_spsr_mode", 32'(spsr_o[4:0]), 32'b10111);
        exc_req = 6'b000100;
        tick();
        tick();
        tick();
        check("irq_masked", 32'(busy), 32'd0);
        exc_req = '0;
        vif.vec_ready = 0;
        $display("txn dabt+fiq done, irq masked");

        // usr mode privilege.
        do_msr(0, 4'b0001, 32'h0000_0010);
        do_msr(0, 4'b1111, 32'hF000_00DF);
        check("usr_msr", cpsr_o, 32'hF000_0010);
        do_msr(1, 4'b1111, 32'h1234_5678);
        check("usr_msr_spsr", cpsr_o, 32'hF000_0010);
        restore_cpsr = 1;
        tick();
        restore_cpsr = 0;
        check("usr_restore", cpsr_o, 32'hF000_0010);

        // svc restore beats a simultaneous flag update.
        take_exc(5);
        do_msr(1, 4'b1111, 32'h6000_0010);
        check("svc_spsr_set", spsr_o, 32'h6000_0010);
        restore_cpsr = 1; flags_we = 1; flags_next = 4'hF;
        tick();
        restore_cpsr = 0; flags_we = 0; flags_next = '0;
        check("restore_over_flags", cpsr_o, 32'h6000_0010);
        $display("txn restore+flags -> cpsr=%h", cpsr_o);

        // Reset while vector pending, with another request latched.
        exc_req = 6'b010000;
        tick();
        exc_req = 6'b001000;
        tick();
        exc_req = '0;
        check("pre_reset_valid", 32'(vif.vec_valid), 32'd1);
        reset = 1;
        #1;
        model_reset();
        check("async_rst_valid", 32'(vif.vec_valid), 32'd0);
        check("async_rst_cpsr", cpsr_o, 32'h0000_00D3);
        check("async_rst_busy", 32'(busy), 32'd0);
        tick();
        reset = 0;
        tick();
        tick();
        check("pending_cleared", 32'(busy), 32'd0);
        $display("txn reset during vector");

        for (int k = 0; k < 3; k++) take_exc(4);
        check("und_vec", 32'(vif.vec_addr), 32'b0000010);
`ifdef LEG_PSR_EXC_COUNT_EN
        check("und_count", 32'(exc_count[4*16 +: 16]), 32'd3);
`endif

        // Random traffic.
        begin
            bit fiq_lvl, irq_lvl;
            fiq_lvl = 0; irq_lvl = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                int op;
                idle_inputs();
                for (int i = 0; i < 6; i++)
                    if (i != 1 && i != 2 && $urandom_range(0, 31) == 0) exc_req[i] = 1'b1;
                if ($urandom_range(0, 19) == 0) fiq_lvl = ~fiq_lvl;
                if ($urandom_range(0, 19) == 0) irq_lvl = ~irq_lvl;
                exc_req[1] = fiq_lvl;
                exc_req[2] = irq_lvl;
                vif.vec_ready = 1'($urandom_range(0, 1));
                op = $urandom_range(0, 9);
                if (op <= 1) begin
                    msr_we   = 1;
                    msr_spsr = ($urandom_range(0, 2) == 0);
                    msr_mask = 4'($urandom_range(0, 15));
                    msr_data = $urandom;
                    if (msr_spsr || $urandom_range(0, 3) != 0)
                        msr_data[4:0] = legal_tbl[$urandom_range(0, 6)];
                end else if (op == 2) begin
                    restore_cpsr = 1;
                end else if (op == 3) begin
                    flags_we   = 1;
                    flags_next = 4'($urandom_range(0, 15));
                end
                tick();
            end
        end

        idle_inputs();
        vif.vec_ready = 0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
